// File: rtl/m2_pkg.sv
// m2_pkg: shared state encoding and constants for the m2 job sequencer
package m2_pkg;
    typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT, DRAIN, DONE} state_t;
    localparam logic [3:0] HEADER_NONCE_WORD = 4'd3;
    localparam int HASH_PERIOD_DEF = 24;
    localparam int ARM_CYCLES_DEF = 2;
endpackage

// File: rtl/m2_job_ctrl_if.sv
// m2_job_ctrl_if: host job, core control and result signals of the m2 job sequencer
interface m2_job_ctrl_if #(parameter int HCNT_W = 32);
    import m2_pkg::*;
    logic              host_break;
    logic              job_valid;
    logic              job_ready;
    logic [31:0]       job_nonce_start;
    logic [31:0]       job_nonce_end;
    logic [31:0]       job_target;
    logic              start_stop;
    logic              go_m2;
    logic [31:0]       nonce;
    logic              nonce_wr;
    logic              hash_done;
    logic [31:0]       hash_word;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_nonce;
    logic              res_lost;
    logic              busy;
    logic              job_done;
    logic [HCNT_W-1:0] hash_count;
    modport slave (
        input  host_break, job_valid, job_nonce_start, job_nonce_end, job_target,
               hash_done, hash_word, res_ready,
        output job_ready, start_stop, go_m2, nonce, nonce_wr, res_valid, res_nonce,
               res_lost, busy, job_done, hash_count
    );
    modport master (
        output host_break, job_valid, job_nonce_start, job_nonce_end, job_target,
               hash_done, hash_word, res_ready,
        input  job_ready, start_stop, go_m2, nonce, nonce_wr, res_valid, res_nonce,
               res_lost, busy, job_done, hash_count
    );
endinterface

// File: rtl/m2_res_reg.sv
// m2_res_reg: one-entry valid/ready result holding register with sticky overflow flag
module m2_res_reg (
    input  logic        clk_h,
    input  logic        rst_n,
    input  logic        hit,
    input  logic [31:0] hit_nonce,
    input  logic        clr_lost,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] nonce,
    output logic        lost
);
    logic        valid_q, valid_d, lost_q, lost_d, take;
    logic [31:0] nonce_q, nonce_d;
    always_comb begin
        take    = hit & (~valid_q | ready);
        valid_d = hit | (valid_q & ~ready);
        nonce_d = take ? hit_nonce : nonce_q;
        lost_d  = clr_lost ? 1'b0 : lost_q | (hit & ~take);
    end
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            nonce_q <= '0;
            lost_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            nonce_q <= nonce_d;
            lost_q  <= lost_d;
        end
    end
    assign valid = valid_q;
    assign nonce = nonce_q;
    assign lost  = lost_q;
endmodule

// File: rtl/m2_job_ctrl.sv
// m2_job_ctrl: nonce-range job sequencer driving the m2 core and collecting target hits
module m2_job_ctrl import m2_pkg::*; #(
    parameter int HASH_PERIOD = HASH_PERIOD_DEF,
    parameter int ARM_CYCLES  = ARM_CYCLES_DEF,
    parameter int HCNT_W      = 32
) (
    input logic         clk_h,
    input logic         rst_n,
    m2_job_ctrl_if.slave bus
);
    localparam int CNT_MAX = HASH_PERIOD > ARM_CYCLES ? HASH_PERIOD : ARM_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       nonce_cur_q, nonce_cur_d, nonce_prev_q, nonce_prev_d;
    logic [31:0]       end_q, end_d, target_q, target_d;
    logic              inflight_q, inflight_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              done_ev, hit, accept;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nonce_cur_d  = nonce_cur_q;
        nonce_prev_d = nonce_prev_q;
        end_d        = end_q;
        target_d     = target_q;
        inflight_d   = inflight_q;
        hcnt_d       = hcnt_q;
        accept       = 1'b0;
        done_ev      = bus.hash_done & inflight_q;
        hit          = done_ev & (bus.hash_word <= target_q);
        if (done_ev) begin
            hcnt_d     = &hcnt_q ? hcnt_q : hcnt_q + 1'b1;
            inflight_d = 1'b0;
        end
        case (state_q)
            IDLE: if (bus.job_valid & ~bus.host_break) begin
                accept      = 1'b1;
                end_d       = bus.job_nonce_end;
                target_d    = bus.job_target;
                nonce_cur_d = bus.job_nonce_start;
                hcnt_d      = '0;
                cnt_d       = CNT_W'(ARM_CYCLES);
                state_d     = ARM;
            end
            ARM, WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? ISSUE : state_q;
            end
            ISSUE: begin
                inflight_d   = 1'b1;
                nonce_prev_d = nonce_cur_q;
                cnt_d        = CNT_W'(HASH_PERIOD - 1);
                // >= also covers start > end as a single launch, and never wraps past end
                state_d      = nonce_cur_q >= end_q ? DRAIN : WAIT;
                nonce_cur_d  = nonce_cur_q >= end_q ? nonce_cur_q : nonce_cur_q + 1'b1;
            end
            DRAIN: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (done_ev || cnt_q == '0) ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        if (bus.host_break) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
        end
    end
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            nonce_cur_q  <= '0;
            nonce_prev_q <= '0;
            end_q        <= '0;
            target_q     <= '0;
            inflight_q   <= 1'b0;
            hcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nonce_cur_q  <= nonce_cur_d;
            nonce_prev_q <= nonce_prev_d;
            end_q        <= end_d;
            target_q     <= target_d;
            inflight_q   <= inflight_d;
            hcnt_q       <= hcnt_d;
        end
    end
    m2_res_reg u_res (
        .clk_h     (clk_h),
        .rst_n     (rst_n),
        .hit       (hit),
        .hit_nonce (nonce_prev_q),
        .clr_lost  (accept),
        .ready     (bus.res_ready),
        .valid     (bus.res_valid),
        .nonce     (bus.res_nonce),
        .lost      (bus.res_lost)
    );
    assign bus.job_ready  = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.start_stop = state_q != IDLE && state_q != DONE;
    assign bus.go_m2      = state_q == ISSUE;
    assign bus.nonce_wr   = state_q == ISSUE;
    assign bus.nonce      = state_q == ISSUE ? nonce_cur_q : '0;
    assign bus.job_done   = state_q == DONE;
    assign bus.hash_count = hcnt_q;
endmodule
